// File: rtl/dsp48_cic_dump_seq.sv
// Sequencer for a single-DSP48 CIC accumulate/dump slice: feeds samples, closes a frame every DECIM samples, emits the scaled frame sum.
// Latency: result valid 5 cycles after the last sample of a frame is accepted; one clear slot per frame (DECIM samples per DECIM+1 cycles).
// Backpressure: s_tready drops on the frame's last sample while the previous result is unconsumed or still in flight; m_tvalid holds until m_tready.
// Optional: define CIC_SEQ_ROUND_EN for round-half-up scaling instead of floor truncation.
module dsp48_cic_dump_seq #(
    parameter int DECIM = 256,
    parameter int CNT_W = 8,
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    s_tvalid,
    input  logic [IN_W-1:0]         s_tdata,
    output logic                    s_tready,
    input  logic                    sync_clear,
    output logic                    m_tvalid,
    output logic [OUT_W-1:0]        m_tdata,
    input  logic                    m_tready,
    output logic [47:0]             dsp_concat,
    output logic                    dsp_opcode,
    input  logic [47:0]             dsp_p
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [47:0]        dsp_concat_q, dsp_concat_d;
    logic               op_slot_q, op_slot_d;     // opcode of the slot currently on dsp_concat
    logic               dsp_opcode_q;             // same opcode, one cycle later as the slice expects
    logic               slot_fe_q, slot_fe_d;     // frame-end mark travelling with dsp_concat
    logic [3:0]         fe_pipe_q;                // frame-end mark delayed to line up with dsp_p
    logic               m_tvalid_q;
    logic [OUT_W-1:0]   m_tdata_q, m_tdata_d;

    logic               last_w;
    logic               inflight_w;
    logic               s_tready_w;
    logic               accept_w;
    logic signed [47:0] p_sum_w;

    assign last_w     = (cnt_q == CNT_W'(DECIM - 1));
    assign inflight_w = slot_fe_q | (|fe_pipe_q);
    // The last sample of a frame is held off until the result register is guaranteed free
    assign s_tready_w = (state_q == ST_ACCUM) && !sync_clear
                        && !(last_w && (m_tvalid_q || inflight_w));
    assign accept_w   = s_tvalid && s_tready_w;

`ifdef CIC_SEQ_ROUND_EN
    localparam logic signed [47:0] RND_K = 48'sd1 <<< (SHIFT - 1);
    assign p_sum_w = $signed(dsp_p) + RND_K;
`else
    assign p_sum_w = $signed(dsp_p);
`endif
    assign m_tdata_d = OUT_W'(p_sum_w >>> SHIFT);

    // Next-state and slot contents: clear slot, sample slot or idle slot
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dsp_concat_d = 48'd0;
        op_slot_d    = 1'b0;
        slot_fe_d    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                op_slot_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (accept_w) begin
                    dsp_concat_d = 48'($signed(s_tdata));
                    cnt_d        = cnt_q + CNT_W'(1);
                    if (last_w) begin
                        slot_fe_d = 1'b1;
                        state_d   = ST_CLEAR;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
        // A sync clear abandons the partial frame; in-flight frame ends are untouched
        if (sync_clear) begin
            state_d = ST_CLEAR;
        end
    end

    // Sequencer state and registered slice drive; reset issues a clear slot first
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= '0;
            dsp_concat_q <= 48'd0;
            op_slot_q    <= 1'b1;
            dsp_opcode_q <= 1'b1;
            slot_fe_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dsp_concat_q <= dsp_concat_d;
            op_slot_q    <= op_slot_d;
            dsp_opcode_q <= op_slot_q;
            slot_fe_q    <= slot_fe_d;
        end
    end

    // Frame-end alignment with dsp_p and the held output register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            fe_pipe_q  <= 4'd0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
        end else begin
            fe_pipe_q <= {fe_pipe_q[2:0], slot_fe_q};
            if (fe_pipe_q[3]) begin
                m_tvalid_q <= 1'b1;
                m_tdata_q  <= m_tdata_d;
            end else if (m_tready) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

    assign s_tready   = s_tready_w;
    assign m_tvalid   = m_tvalid_q;
    assign m_tdata    = m_tdata_q;
    assign dsp_concat = dsp_concat_q;
    assign dsp_opcode = dsp_opcode_q;

endmodule

// File: tb/tb_dsp48_cic_dump_seq.sv
// Directed bench: two sequencers (SHIFT=1 and SHIFT=2, DECIM=8) driven in lockstep, each with its own slice model.
// Slice model: concat at slot s, opcode at s+1, result visible on dsp_p at s+4.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_dsp48_cic_dump_seq;

    logic               clk = 1'b0;
    logic               aresetn;
    logic               s_tvalid;
    logic [15:0]        s_tdata;
    logic               sync_clear;
    logic               m_tready;

    logic               s_tready0, s_tready1;
    logic               m_tvalid0, m_tvalid1;
    logic signed [31:0] m_tdata0, m_tdata1;
    logic [47:0]        cat0, cat1;
    logic               op0, op1;
    logic [47:0]        p0 = 48'd0, p1 = 48'd0;

    logic [47:0]        c0_d1 = 48'd0, pi0 = 48'd0, pd0 = 48'd0;
    logic [47:0]        c1_d1 = 48'd0, pi1 = 48'd0, pd1 = 48'd0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dsp48_cic_dump_seq #(.DECIM(8), .CNT_W(3), .IN_W(16), .OUT_W(32), .SHIFT(1)) dut0 (
        .clk(clk), .aresetn(aresetn), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(s_tready0),
        .sync_clear(sync_clear), .m_tvalid(m_tvalid0), .m_tdata(m_tdata0), .m_tready(m_tready),
        .dsp_concat(cat0), .dsp_opcode(op0), .dsp_p(p0)
    );

    dsp48_cic_dump_seq #(.DECIM(8), .CNT_W(3), .IN_W(16), .OUT_W(32), .SHIFT(2)) dut1 (
        .clk(clk), .aresetn(aresetn), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(s_tready1),
        .sync_clear(sync_clear), .m_tvalid(m_tvalid1), .m_tdata(m_tdata1), .m_tready(m_tready),
        .dsp_concat(cat1), .dsp_opcode(op1), .dsp_p(p1)
    );

    // Slice models: opcode 1 clears P, opcode 0 adds the concat of the matching slot
    always @(posedge clk) begin
        c0_d1 <= cat0;
        pi0   <= op0 ? 48'd0 : pi0 + c0_d1;
        pd0   <= pi0;
        p0    <= pd0;
        c1_d1 <= cat1;
        pi1   <= op1 ? 48'd0 : pi1 + c1_d1;
        pd1   <= pi1;
        p1    <= pd1;
    end

    task automatic chk(input string tag, input logic signed [47:0] obs, input logic signed [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample and return on the falling edge right after it was taken
    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        #1;
        while (!s_tready0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!s_tready0) chk("send_timeout", 48'(s_tready0), 48'sd1);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tdata  = 16'd0;
    endtask

    task automatic send_n(input int cnt, input logic [15:0] d);
        for (int i = 0; i < cnt; i++) send(d);
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!m_tvalid0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!m_tvalid0) chk("result_timeout", 48'(m_tvalid0), 48'sd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c_first;
        int c_last;
        aresetn    = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = 16'd0;
        sync_clear = 1'b0;
        m_tready   = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_m_tvalid", 48'(m_tvalid0), 48'sd0);
        chk("rst_m_tdata", 48'(m_tdata0), 48'sd0);
        chk("rst_concat", cat0, 48'sd0);
        chk("rst_opcode", 48'(op0), 48'sd1);
        chk("rst_s_tready", 48'(s_tready0), 48'sd0);
        chk("rst_s_tready_b", 48'(s_tready1), 48'sd0);
        aresetn = 1'b1;
        @(negedge clk);

        // T1: 1..8 back-to-back, sum 36
        send(16'd1);
        c_first = cyc;
        for (int i = 2; i <= 8; i++) send(16'(i));
        c_last = cyc;
        chk("t1_back_to_back", 48'(c_last - c_first), 48'sd7);
        chk("t1_rdy_low_after_last", 48'(s_tready0), 48'sd0);
        repeat (4) @(negedge clk);
        chk("t1_vld_not_early", 48'(m_tvalid0), 48'sd0);
        @(negedge clk);
        chk("t1_vld_at_5", 48'(m_tvalid0), 48'sd1);
        chk("t1_dat_shift1", m_tdata0, 48'sd18);
        chk("t1_dat_shift2", m_tdata1, 48'sd9);
        @(negedge clk);
        chk("t1_vld_cleared", 48'(m_tvalid0), 48'sd0);

        // T2: eight -3 then eight 2, no carry-over
        send_n(8, 16'hFFFD);
        wait_result();
        chk("t2_neg_shift1", m_tdata0, -48'sd12);
        chk("t2_neg_shift2", m_tdata1, -48'sd6);
        @(negedge clk);
        send_n(8, 16'd2);
        wait_result();
        chk("t2_pos_shift1", m_tdata0, 48'sd8);
        chk("t2_pos_shift2", m_tdata1, 48'sd4);
        @(negedge clk);

        // T3: downstream stalled across two frames
        m_tready = 1'b0;
        send_n(8, 16'd1);
        send_n(7, 16'd2);
        s_tvalid = 1'b1;
        s_tdata  = 16'd2;
        repeat (5) @(negedge clk);
        chk("t3_last_stalled", 48'(s_tready0), 48'sd0);
        chk("t3_first_held", 48'(m_tvalid0), 48'sd1);
        chk("t3_first_dat", m_tdata0, 48'sd4);
        m_tready = 1'b1;
        @(negedge clk);
        m_tready = 1'b0;
        chk("t3_first_taken", 48'(m_tvalid0), 48'sd0);
        send(16'd2);
        wait_result();
        repeat (3) @(negedge clk);
        chk("t3_second_held", 48'(m_tvalid0), 48'sd1);
        chk("t3_second_dat", m_tdata0, 48'sd8);
        chk("t3_second_dat_b", m_tdata1, 48'sd4);
        m_tready = 1'b1;
        @(negedge clk);

        // T4: reset mid-frame
        send_n(5, 16'd1);
        chk("t4_concat_pre", cat0, 48'sd1);
        aresetn = 1'b0;
        #1;
        chk("t4_rst_m_tvalid", 48'(m_tvalid0), 48'sd0);
        chk("t4_rst_m_tdata", m_tdata0, 48'sd0);
        chk("t4_rst_concat", cat0, 48'sd0);
        chk("t4_rst_opcode", 48'(op0), 48'sd1);
        chk("t4_rst_s_tready", 48'(s_tready0), 48'sd0);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        send_n(8, 16'd1);
        wait_result();
        chk("t4_post_reset_dat", m_tdata0, 48'sd4);
        chk("t4_post_reset_dat_b", m_tdata1, 48'sd2);
        @(negedge clk);

        // T5: sync_clear discards a partial frame and wins over a coincident valid
        send_n(3, 16'd5);
        sync_clear = 1'b1;
        s_tvalid   = 1'b1;
        s_tdata    = 16'd5;
        #1;
        chk("t5_rdy_during_sync", 48'(s_tready0), 48'sd0);
        @(negedge clk);
        sync_clear = 1'b0;
        s_tvalid   = 1'b0;
        #1;
        chk("t5_rdy_clear_slot", 48'(s_tready0), 48'sd0);
        send_n(8, 16'd1);
        wait_result();
        chk("t5_dat", m_tdata0, 48'sd4);
        repeat (10) @(negedge clk);
        chk("t5_single_result", 48'(m_tvalid0), 48'sd0);

        // T6: rounding vs truncation on the SHIFT=2 instance
        send(16'd6);
        send_n(7, 16'd0);
        wait_result();
        chk("t6_pos_shift1", m_tdata0, 48'sd3);
`ifdef CIC_SEQ_ROUND_EN
        chk("t6_pos_shift2", m_tdata1, 48'sd2);
`else
        chk("t6_pos_shift2", m_tdata1, 48'sd1);
`endif
        @(negedge clk);
        send(16'hFFFA);
        send_n(7, 16'd0);
        wait_result();
        chk("t6_neg_shift1", m_tdata0, -48'sd3);
`ifdef CIC_SEQ_ROUND_EN
        chk("t6_neg_shift2", m_tdata1, -48'sd1);
`else
        chk("t6_neg_shift2", m_tdata1, -48'sd2);
`endif
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
